// File: rtl/free_list_if.sv
// ============================================================================
// Module      : free_list_if
// Description : Dispatch/retire handshake bundle for the physical-register
//               free list (grant lanes, retire lanes, rollback, occupancy).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif
`ifndef N
`define N 3
`endif

interface free_list_if #(
    parameter int DEPTH = `PHYS_REG_SZ - `ARCH_REG_SZ,
    parameter int N     = `N,
    parameter int TAG_W = $clog2(`PHYS_REG_SZ + 1)
);
    localparam int AV_W  = $clog2(N + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [N-1:0]             alloc_req;
    logic [N-1:0]             retire_valid;
    logic [N-1:0][TAG_W-1:0]  retire_reg;
    logic                     rollback;
    logic [N-1:0][TAG_W-1:0]  free_reg;
    logic [N-1:0]             free_valid;
    logic [AV_W-1:0]          num_avail;
    logic [CNT_W-1:0]         num_free;

    modport master (
        output alloc_req, retire_valid, retire_reg, rollback,
        input  free_reg, free_valid, num_avail, num_free
    );

    modport slave (
        input  alloc_req, retire_valid, retire_reg, rollback,
        output free_reg, free_valid, num_avail, num_free
    );
endinterface

`default_nettype wire

// File: rtl/free_list.sv
// ============================================================================
// Module      : free_list
// Description : Circular physical-register free list with single-cycle
//               rollback. Optional same-cycle retire-to-allocate forwarding
//               is enabled by defining FL_RETIRE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif
`ifndef N
`define N 3
`endif

module free_list #(
    parameter int DEPTH = `PHYS_REG_SZ - `ARCH_REG_SZ,
    parameter int N     = `N
) (
    input  wire logic  clock,
    input  wire logic  reset,
    free_list_if.slave fl
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AV_W  = $clog2(N + 1);
    localparam int TAG_W = $clog2(`PHYS_REG_SZ + 1);

    logic [TAG_W-1:0] entry_q [DEPTH];
    logic [TAG_W-1:0] entry_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [TAG_W-1:0] rtag [N];
    int               n_ret;
    int               n_grant;
    int               n_byp;
    int               g;
    int               cnt;
    int               avail;

    // Offsets never exceed N, so a single conditional subtract wraps correctly
    // even for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ring_add(input logic [PTR_W-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    always_comb begin
        entry_d       = entry_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        fl.free_reg   = '0;
        fl.free_valid = '0;
        n_ret         = 0;
        n_grant       = 0;
        n_byp         = 0;
        g             = 0;
        cnt           = int'(count_q);
        for (int r = 0; r < N; r++) rtag[r] = '0;

        // Compact non-zero retiring tags in lane order.
        for (int i = 0; i < N; i++) begin
            if (fl.retire_valid[i] && (fl.retire_reg[i] != '0)) begin
                for (int r = 0; r < N; r++) begin
                    if (r == n_ret) rtag[r] = fl.retire_reg[i];
                end
                n_ret = n_ret + 1;
            end
        end

`ifdef FL_RETIRE_BYPASS_EN
        avail = fl.rollback ? cnt : cnt + n_ret;
`else
        avail = cnt;
`endif
        fl.num_avail = AV_W'((avail < N) ? avail : N);
        fl.num_free  = count_q;

        for (int i = 0; i < N; i++) begin
            if (fl.alloc_req[i]) begin
                if (!fl.rollback && (g < avail)) begin
                    fl.free_valid[i] = 1'b1;
                    if (g < cnt) begin
                        fl.free_reg[i] = entry_q[ring_add(head_q, g)];
                    end else begin
                        for (int r = 0; r < N; r++) begin
                            if (r == g - cnt) fl.free_reg[i] = rtag[r];
                        end
                        n_byp = n_byp + 1;
                    end
                    n_grant = n_grant + 1;
                end
                g = g + 1;
            end
        end

        // Forwarded tags are consumed immediately and skip storage.
        for (int r = 0; r < N; r++) begin
            if ((r < n_ret) && (r >= n_byp)) entry_d[ring_add(tail_q, r)] = rtag[r];
        end

        head_d  = ring_add(head_q, n_grant);
        tail_d  = ring_add(tail_q, n_ret);
        count_d = CNT_W'(cnt + n_ret - n_grant);

        if (fl.rollback) begin
            head_d  = tail_d;
            count_d = CNT_W'(DEPTH);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(DEPTH);
            for (int k = 0; k < DEPTH; k++) entry_q[k] <= TAG_W'(`ARCH_REG_SZ + 1 + k);
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            entry_q <= entry_d;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_free_list.sv
// ============================================================================
// Module      : tb_free_list
// Description : Directed self-checking bench for free_list (ARCH=32, DEPTH=32,
//               N=3); expectations follow FL_RETIRE_BYPASS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_free_list;
    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    free_list_if ifc ();

    free_list dut (
        .clock (clock),
        .reset (reset),
        .fl    (ifc.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ifc.alloc_req    = '0;
        ifc.retire_valid = '0;
        ifc.retire_reg   = '0;
        ifc.rollback     = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (ifc.num_free !== 6'd32) begin n_bad++; $display("FAIL reset_num_free: got %0d want 32", ifc.num_free); end
        n_cmp++; if (ifc.num_avail !== 2'd3) begin n_bad++; $display("FAIL reset_num_avail: got %0d want 3", ifc.num_avail); end
        n_cmp++; if (ifc.free_valid !== 3'b000) begin n_bad++; $display("FAIL reset_free_valid: got %b want 000", ifc.free_valid); end
        n_cmp++; if (ifc.free_reg !== 21'd0) begin n_bad++; $display("FAIL reset_free_reg: got %h want 0", ifc.free_reg); end
    endtask

    task automatic test_alloc_all_lanes();
        do_reset();
        ifc.alloc_req = 3'b111;
        #1;
        n_cmp++; if (ifc.free_reg !== {7'd35, 7'd34, 7'd33}) begin n_bad++; $display("FAIL alloc3_tags: got %0d,%0d,%0d want 35,34,33", ifc.free_reg[2], ifc.free_reg[1], ifc.free_reg[0]); end
        n_cmp++; if (ifc.free_valid !== 3'b111) begin n_bad++; $display("FAIL alloc3_valid: got %b want 111", ifc.free_valid); end
        tick();
        ifc.alloc_req = 3'b111;
        #1;
        n_cmp++; if (ifc.num_free !== 6'd29) begin n_bad++; $display("FAIL alloc3_num_free: got %0d want 29", ifc.num_free); end
        n_cmp++; if (ifc.free_reg !== {7'd38, 7'd37, 7'd36}) begin n_bad++; $display("FAIL alloc3_second: got %0d,%0d,%0d want 38,37,36", ifc.free_reg[2], ifc.free_reg[1], ifc.free_reg[0]); end
        tick();
        idle();
    endtask

    task automatic test_alloc_sparse();
        do_reset();
        ifc.alloc_req = 3'b101;
        #1;
        n_cmp++; if (ifc.free_valid !== 3'b101) begin n_bad++; $display("FAIL sparse_valid: got %b want 101", ifc.free_valid); end
        n_cmp++; if (ifc.free_reg[0] !== 7'd33) begin n_bad++; $display("FAIL sparse_lane0: got %0d want 33", ifc.free_reg[0]); end
        n_cmp++; if (ifc.free_reg[2] !== 7'd34) begin n_bad++; $display("FAIL sparse_lane2: got %0d want 34", ifc.free_reg[2]); end
        n_cmp++; if (ifc.free_reg[1] !== 7'd0) begin n_bad++; $display("FAIL sparse_lane1: got %0d want 0", ifc.free_reg[1]); end
        tick();
        ifc.alloc_req = 3'b001;
        #1;
        n_cmp++; if (ifc.num_free !== 6'd30) begin n_bad++; $display("FAIL sparse_num_free: got %0d want 30", ifc.num_free); end
        n_cmp++; if (ifc.free_reg[0] !== 7'd35) begin n_bad++; $display("FAIL sparse_head: got %0d want 35", ifc.free_reg[0]); end
        tick();
        idle();
    endtask

    task automatic test_empty_retire();
        logic [2:0] exp_fv;
        logic [6:0] exp_tag;
        logic [1:0] exp_av;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            ifc.alloc_req = 3'b111;
            tick();
        end
        ifc.alloc_req = 3'b011;
        tick();
        idle();
        #1;
        n_cmp++; if (ifc.num_free !== 6'd0) begin n_bad++; $display("FAIL empty_num_free: got %0d want 0", ifc.num_free); end
        n_cmp++; if (ifc.num_avail !== 2'd0) begin n_bad++; $display("FAIL empty_num_avail: got %0d want 0", ifc.num_avail); end
        ifc.alloc_req       = 3'b111;
        ifc.retire_valid    = 3'b010;
        ifc.retire_reg[1]   = 7'd5;
        #1;
`ifdef FL_RETIRE_BYPASS_EN
        exp_fv = 3'b001;
        n_cmp++; if (ifc.free_reg[0] !== 7'd5) begin n_bad++; $display("FAIL empty_bypass_tag: got %0d want 5", ifc.free_reg[0]); end
`else
        exp_fv = 3'b000;
`endif
        n_cmp++; if (ifc.free_valid !== exp_fv) begin n_bad++; $display("FAIL empty_same_cycle_valid: got %b want %b", ifc.free_valid, exp_fv); end
        tick();
        idle();
        ifc.alloc_req = 3'b001;
        #1;
`ifdef FL_RETIRE_BYPASS_EN
        exp_av = 2'd0; exp_fv = 3'b000; exp_tag = 7'd0;
`else
        exp_av = 2'd1; exp_fv = 3'b001; exp_tag = 7'd5;
`endif
        n_cmp++; if (ifc.num_avail !== exp_av) begin n_bad++; $display("FAIL empty_next_avail: got %0d want %0d", ifc.num_avail, exp_av); end
        n_cmp++; if (ifc.free_valid !== exp_fv) begin n_bad++; $display("FAIL empty_next_valid: got %b want %b", ifc.free_valid, exp_fv); end
        n_cmp++; if (ifc.free_reg[0] !== exp_tag) begin n_bad++; $display("FAIL empty_next_tag: got %0d want %0d", ifc.free_reg[0], exp_tag); end
        tick();
        idle();
    endtask

    task automatic test_retire_compact();
        do_reset();
        ifc.alloc_req = 3'b111;
        tick();
        idle();
        ifc.retire_valid = 3'b111;
        ifc.retire_reg   = {7'd0, 7'd7, 7'd9};
        tick();
        idle();
        ifc.alloc_req = 3'b001;
        #1;
        n_cmp++; if (ifc.num_free !== 6'd31) begin n_bad++; $display("FAIL compact_num_free: got %0d want 31", ifc.num_free); end
        n_cmp++; if (ifc.free_reg[0] !== 7'd36) begin n_bad++; $display("FAIL compact_head_tag: got %0d want 36", ifc.free_reg[0]); end
        idle();
        // drain slots 3..31 so the head reaches the retired entries
        for (int k = 0; k < 9; k++) begin
            ifc.alloc_req = 3'b111;
            tick();
        end
        ifc.alloc_req = 3'b011;
        tick();
        ifc.alloc_req = 3'b111;
        #1;
        n_cmp++; if (ifc.free_valid !== 3'b011) begin n_bad++; $display("FAIL compact_valid: got %b want 011", ifc.free_valid); end
        n_cmp++; if (ifc.free_reg[0] !== 7'd9) begin n_bad++; $display("FAIL compact_first: got %0d want 9", ifc.free_reg[0]); end
        n_cmp++; if (ifc.free_reg[1] !== 7'd7) begin n_bad++; $display("FAIL compact_second: got %0d want 7", ifc.free_reg[1]); end
        tick();
        idle();
    endtask

    task automatic test_rollback();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            ifc.alloc_req = 3'b111;
            tick();
        end
        ifc.alloc_req = 3'b001;
        tick();
        idle();
        ifc.retire_valid = 3'b111;
        ifc.retire_reg   = {7'd3, 7'd2, 7'd1};
        tick();
        idle();
        ifc.retire_valid  = 3'b001;
        ifc.retire_reg[0] = 7'd4;
        tick();
        idle();
        ifc.rollback      = 1'b1;
        ifc.alloc_req     = 3'b111;
        ifc.retire_valid  = 3'b011;
        ifc.retire_reg[0] = 7'd5;
        ifc.retire_reg[1] = 7'd6;
        #1;
        n_cmp++; if (ifc.free_valid !== 3'b000) begin n_bad++; $display("FAIL rollback_valid: got %b want 000", ifc.free_valid); end
        n_cmp++; if (ifc.free_reg !== 21'd0) begin n_bad++; $display("FAIL rollback_reg: got %h want 0", ifc.free_reg); end
        tick();
        idle();
        ifc.alloc_req = 3'b111;
        #1;
        n_cmp++; if (ifc.num_free !== 6'd32) begin n_bad++; $display("FAIL rollback_num_free: got %0d want 32", ifc.num_free); end
        n_cmp++; if (ifc.free_reg !== {7'd41, 7'd40, 7'd39}) begin n_bad++; $display("FAIL rollback_head_eq_tail: got %0d,%0d,%0d want 41,40,39", ifc.free_reg[2], ifc.free_reg[1], ifc.free_reg[0]); end
        tick();
        idle();
    endtask

    task automatic test_wrap();
        int q[$];
        int exp;
        logic [6:0] prev;
        do_reset();
        for (int k = 0; k < 32; k++) q.push_back(33 + k);
        prev = '0;
        for (int k = 0; k < 40; k++) begin
            ifc.alloc_req     = 3'b001;
            ifc.retire_valid  = (k == 0) ? 3'b000 : 3'b001;
            ifc.retire_reg[0] = prev;
            #1;
            exp = q.pop_front();
            n_cmp++; if (ifc.free_valid[0] !== 1'b1 || int'(ifc.free_reg[0]) != exp) begin n_bad++; $display("FAIL wrap_tag[%0d]: got %0d valid %b want %0d", k, ifc.free_reg[0], ifc.free_valid[0], exp); end
            if (k != 0) q.push_back(int'(prev));
            prev = ifc.free_reg[0];
            tick();
        end
        idle();
        ifc.retire_valid  = 3'b001;
        ifc.retire_reg[0] = prev;
        tick();
        idle();
        #1;
        n_cmp++; if (ifc.num_free !== 6'd32) begin n_bad++; $display("FAIL wrap_num_free: got %0d want 32", ifc.num_free); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        idle();
        test_reset();
        test_alloc_all_lanes();
        test_alloc_sparse();
        test_empty_retire();
        test_retire_compact();
        test_rollback();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/free_list.md
# free_list

Physical-register free list for the R10K rename stage. It supplies up to `N` free physical register tags per cycle to the map table at dispatch and reclaims up to `N` T_old tags per cycle from the ROB at retirement. It is a circular buffer with head and tail pointers. On a branch mispredict it recovers in a single cycle by marking every uncommitted allocation free again.

## Interface
Parameters:
- `DEPTH`, default `` `PHYS_REG_SZ - `ARCH_REG_SZ ``: number of non-architectural physical registers, which is also the buffer size.
- `N`, default `` `N ``: superscalar width.

Ports:
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `alloc_req` in `[N-1:0]`: dispatch lane i wants a new destination tag.
- `retire_valid` in `[N-1:0]`: retiring lane i returns a tag.
- `retire_reg` in `PHYS_REG_IDX [N-1:0]`: T_old tag of retiring lane i.
- `rollback` in 1: mispredict recovery; squash all uncommitted allocations.
- `free_reg` out `PHYS_REG_IDX [N-1:0]`: tag granted to lane i.
- `free_valid` out `[N-1:0]`: lane i was granted `free_reg[i]` this cycle.
- `num_avail` out `$clog2(N+1)`: equals min(free count, N). Dispatch never requests more lanes than this.
- `num_free` out `$clog2(DEPTH+1)`: registered free count.

## Operation
- Storage and state:
  - `DEPTH` entries of `PHYS_REG_IDX`.
  - `head` and `tail`, each `$clog2(DEPTH)` bits, wrapping modulo `DEPTH` (`DEPTH` need not be a power of two).
  - `count`, 0..`DEPTH`.
- Free slots are the ring positions [head, head+count). Slots [tail, head) hold uncommitted allocations in program order.
- Reset:
  - entry k = `ARCH_REG_SZ`+1+k.
  - head = tail = 0, count = `DEPTH`.
  - Physical tags 1..`ARCH_REG_SZ` are the initial architectural mappings. Tag 0 is never allocated.
- Allocation:
  - Lane i's grant offset g_i = popcount(`alloc_req[i-1:0]`).
  - `free_valid[i]` = `alloc_req[i]` && g_i < count && !`rollback`.
  - `free_reg[i]` = entry[(head+g_i) mod `DEPTH`]. The value is don't-care when `free_valid[i]`=0; drive it to 0.
  - head advances by the number of grants. Requests beyond count are dropped, not queued.
- Retirement:
  - Valid lanes whose `retire_reg` ≠ 0 are compacted in lane order.
  - The r-th accepted tag is written to entry[(tail+r) mod `DEPTH`], and tail advances by the accepted total.
  - A tag of 0 is ignored.
  - Retirement never overflows: the number of in-flight allocations is always ≥ the number of retirements.
- Count update: count_next = count + accepted_retires − grants.
- Rollback:
  - Retirement writes that cycle still apply.
  - Then head_next = tail_next and count_next = `DEPTH`.
  - No grants are issued in the rollback cycle.
- Rollback and allocation in the same cycle: allocation loses.
- Reset and rollback together: reset wins.

## Timing
- `free_reg`, `free_valid`, and `num_avail` are combinational from registered state plus `alloc_req` and `rollback`. They carry no bypass path from the retire inputs unless the configuration macro is enabled.
- Pointer, count, and entry updates take effect on the next rising edge.
- A tag retired in cycle t is allocatable in cycle t+1.
- After a rollback in cycle t, `num_free` = `DEPTH` in cycle t+1.
- Reset values:
  - `num_free` = `DEPTH`
  - `num_avail` = min(`DEPTH`, `N`)
  - `free_valid` = 0 with no requests
  - `free_reg` = 0 for ungranted lanes
- Empty (count = 0): `num_avail` = 0 and all `free_valid` = 0. A simultaneous retirement does not satisfy requests in that cycle.
- Full (count = `DEPTH`, head = tail): this is legal. Retirement is illegal in this state because no allocations are outstanding.

## Configuration
- `FL_RETIRE_BYPASS_EN` defined:
  - Tags accepted from retirement this cycle are forwarded to allocation.
  - `num_avail` = min(count + accepted_retires, `N`).
  - Grant offsets g_i ≥ count take the (g_i − count)-th compacted retire tag. These tags are not written to storage; tail still advances.
  - Bypass is suppressed during `rollback`.
- Undefined: retired tags are allocatable from the next cycle only, which is the baseline behaviour above.

## Test plan
Configuration for all scenarios: `ARCH_REG_SZ`=32, `DEPTH`=32, `N`=3.
- Reset, then `alloc_req`=3'b111 → `free_reg`={35,34,33}, `free_valid`=3'b111; next cycle `num_free`=29.
- `alloc_req`=3'b101 → lane0 gets 33, lane2 gets 34, lane1 `free_valid`=0; head advances by 2.
- Allocate all 32 tags, then request 3'b111 → `num_avail`=0, `free_valid`=0. Retire tag 5 on lane 1 → next cycle `num_avail`=1 and `alloc_req`=3'b001 gets 5. With bypass: 5 is granted in the same cycle.
- Retire `retire_valid`=3'b111 with `retire_reg`={0,7,9} → only 9 and 7 are stored, in that order, and tail advances by 2.
- Allocate 10, retire 4, assert `rollback` together with 2 more retires and `alloc_req`=3'b111 → no grants; next cycle `num_free`=32 and head = tail.
- Cycle through 40 allocate/retire pairs → pointers wrap modulo 32, and the tag sequence matches the FIFO model.
